piso_shift_register: RTL and testbench
======================================

Name: piso_shift_register

Overview:
- Parallel-in, serial-out shift register: the transmit end feeding the team's serial-in, parallel-out shift register.
- It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first, one bit per enabled clock.
- Bit order is chosen so a downstream SIPO stage (input at q0, shifting toward q[WIDTH-1]) holds q[i] = word[i] after WIDTH enabled shifts.
- It sits between a word producer and any SIPO-type receiver in the design.

Parameters:
- WIDTH, 4, data word width in bits; legal range >= 2.

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- pdata  input  WIDTH  parallel word to transmit.
- load_valid  input  1  producer has a word on pdata.
- load_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  advance the serial stream; 0 stalls all shifting.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a live bit.
- last  output  1  high while sout is the final bit of a frame.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, shift register=0, counter=0, sout=0, sout_valid=0, last=0, load_ready=1.
- States:
  - IDLE: load_ready=1, sout_valid=0.
  - SHIFT: sout_valid=1.
- Load: occurs on a rising edge with load_valid=1 and load_ready=1. The shift register captures pdata, the counter is set to WIDTH-1, and the state becomes SHIFT.
- Load latency: the bit pdata[WIDTH-1] appears on sout in the cycle after the load edge. shift_en is ignored on the load edge itself.
- SHIFT with shift_en=1:
  - On each edge the register shifts left and the counter decrements.
  - sout = register[WIDTH-1] combinationally from the register; no extra latency.
- SHIFT with shift_en=0: the register, counter, sout, sout_valid and last all hold.
- last = 1 while in SHIFT with counter == 0.
- load_ready = (state==IDLE) or (last and shift_en). This allows gapless back-to-back frames.
- End of frame:
  - Final bit shifted, no new load: go to IDLE; sout_valid=0 next cycle; sout returns to 0.
  - Final bit shifted with a simultaneous load: reload and stay in SHIFT. The next word's MSB follows immediately with no idle cycle.
- A frame occupies exactly WIDTH enabled cycles.
- load_valid is ignored while load_ready=0. pdata changes mid-frame have no effect.
- Reset mid-frame aborts the frame immediately: outputs return to reset values asynchronously and no partial-frame completion occurs.
- Counter width is $clog2(WIDTH+1) bits, unsigned, with no wrap beyond 0.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one additional even-parity bit (XOR of the loaded word) is sent, so a frame is WIDTH+1 enabled cycles.
  - last is asserted on the parity bit, not on data bit 0.
  - Parity is computed and stored at load.
  - The counter loads WIDTH instead of WIDTH-1.
  - Back-to-back rules apply to the parity cycle.
- Undefined: no parity logic, no extra cycle, behaviour exactly as above.

Decomposition:
- Shared package piso_pkg:
  - state enum {ST_IDLE, ST_SHIFT}.
  - Function cnt_w(WIDTH) returning $clog2(WIDTH+1).
  - Constant PARITY_EVEN = 1'b0 for the parity seed.
- One natural sub-module: piso_bit_counter (loadable down-counter with enable and zero flag). The data path and FSM stay in the top.

Test Plan:
- Reset: hold RST=0 with load_valid=1 and pdata=4'hF → load_ready=1, sout_valid=0, sout=0, last=0 throughout. Release RST → first load is accepted on the next edge.
- Single frame, WIDTH=4, shift_en=1, pdata=4'b1011 loaded:
  - sout sequence = 1,0,1,1 on cycles 1-4.
  - sout_valid=1 for exactly 4 cycles; last=1 only in cycle 4.
  - Feeding sout into the SIPO stage yields q3..q0 = 1011.
- Back-to-back: load 4'hA, then assert load_valid with 4'h5 during last → sout = 1,0,1,0,0,1,0,1 with no gap, and last high in cycles 4 and 8.
- Stall: load 4'b1100, drop shift_en for 3 cycles after the first bit → sout, sout_valid and last hold for those cycles; load_ready stays 0; the frame completes with the correct 1,1,0,0.
- Reset mid-frame: load 4'b0110, assert RST=0 after 2 bits → sout_valid=0 and sout=0 immediately. After release, loading 4'b1001 produces 1,0,0,1 cleanly.
- With PISO_PARITY_EN: load 4'b1011 → sout = 1,0,1,1,1 (parity bit 1), last only in cycle 5. Load 4'b0011 → parity bit 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in, serial-out shift register.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Seed for the optional parity bit; 0 gives even parity over the word.
  localparam logic PARITY_EVEN = 1'b0;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shift_register_if.sv
// Word-in / bit-out bus of the PISO shift register.
interface piso_shift_register_if #(
  parameter int WIDTH = 4
) ();
  logic [WIDTH-1:0] pdata;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             last;

  modport master (
    output pdata, load_valid, shift_en,
    input  load_ready, sout, sout_valid, last
  );

  modport slave (
    input  pdata, load_valid, shift_en,
    output load_ready, sout, sout_valid, last
  );
endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with enable and zero flag; stops at zero.
module piso_bit_counter #(
  parameter int CW = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign zero = (cnt_reg == '0);
endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register, MSB first, valid/ready word load.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_shift_register
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  piso_shift_register_if.slave    bus
);
`ifdef PISO_PARITY_EN
  localparam int SR_W = WIDTH + 1;
`else
  localparam int SR_W = WIDTH;
`endif
  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SR_W - 1);

  state_t          state_reg;
  logic [SR_W-1:0] sreg_reg;
  logic [SR_W-1:0] load_word;
  logic            cnt_zero;
  logic            load_fire;
  logic            shifting;

`ifdef PISO_PARITY_EN
  // Parity rides in the register LSB so it falls out right after data bit 0.
  assign load_word = {bus.pdata, (^bus.pdata) ^ PARITY_EVEN};
`else
  assign load_word = bus.pdata;
`endif

  assign shifting       = (state_reg == ST_SHIFT) && bus.shift_en;
  assign bus.sout_valid = (state_reg == ST_SHIFT);
  assign bus.last       = (state_reg == ST_SHIFT) && cnt_zero;
  assign bus.load_ready = (state_reg == ST_IDLE) || (bus.last && bus.shift_en);
  assign bus.sout       = bus.sout_valid & sreg_reg[SR_W-1];
  assign load_fire      = bus.load_valid && bus.load_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
      sreg_reg  <= '0;
    end else if (load_fire) begin
      // Covers both an idle load and a reload on the final bit of a frame.
      state_reg <= ST_SHIFT;
      sreg_reg  <= load_word;
    end else if (shifting) begin
      sreg_reg <= {sreg_reg[SR_W-2:0], 1'b0};
      if (cnt_zero) begin
        state_reg <= ST_IDLE;
      end
    end
  end

  piso_bit_counter #(
    .CW (CW)
  ) u_counter (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load_fire),
    .load_val (CNT_LOAD),
    .dec      (shifting && !load_fire),
    .zero     (cnt_zero)
  );
endmodule

// File: tb/tb_piso_shift_register.sv
// Self-checking bench for piso_shift_register (WIDTH=4): vector table,
// reset sequences and a randomized run against a bit-queue reference model.
module tb_piso_shift_register;
`ifdef PISO_PARITY_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  typedef struct {
    logic       lv;
    logic [3:0] pd;
    logic       se;
    logic       sout;
    logic       sv;
    logic       last;
    logic       rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t tbl[$];
  logic q_bits[$];
  logic [3:0] sipo;

  piso_shift_register_if #(.WIDTH(4)) bus ();

  piso_shift_register #(.WIDTH(4)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic lv, logic [3:0] pd, logic se,
                              logic so, logic sv, logic la, logic rd);
    vec_t v;
    v.lv = lv; v.pd = pd; v.se = se;
    v.sout = so; v.sv = sv; v.last = la; v.rdy = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic so, input logic sv,
                         input logic la, input logic rd);
    chk({tag, " sout"}, bus.sout, so);
    chk({tag, " sout_valid"}, bus.sout_valid, sv);
    chk({tag, " last"}, bus.last, la);
    chk({tag, " load_ready"}, bus.load_ready, rd);
  endtask

  task automatic step(input logic lv, input logic [3:0] pd, input logic se);
    @(negedge clk);
    bus.load_valid = lv;
    bus.pdata      = pd;
    bus.shift_en   = se;
    #1;
  endtask

  function automatic logic bit_of(input logic [3:0] w, input int i);
    return w[i];
  endfunction

  initial begin
    logic [3:0] word;
    logic [3:0] mid_word;
    logic       exp_so, exp_sv, exp_la, exp_rd, lv, se;

    // Reset held with a pending load: nothing may start.
    rst_n = 1'b0;
    bus.load_valid = 1'b1;
    bus.pdata      = 4'hF;
    bus.shift_en   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk_out("reset_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release ready", bus.load_ready, 1'b1);
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 4'h0, 1'b1);
      chk("release frame valid", bus.sout_valid, 1'b1);
      chk("release frame sout", bus.sout, (i < 4) ? 1'b1 : 1'b0);
    end
    step(1'b0, 4'h0, 1'b1);
    chk_out("release idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Vector table: single frame, back-to-back frames, stalled frame.
`ifdef PISO_PARITY_EN
    tbl.push_back(mk(1, 4'hB, 1,  0, 0, 0, 1));
    tbl.push_back(mk(0, 4'h0, 1,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  1, 1, 0, 0));
    tbl.push_back(mk(1, 4'h3, 1,  1, 1, 1, 1));
    tbl.push_back(mk(0, 4'h0, 1,  0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  0, 1, 1, 1));
    tbl.push_back(mk(0, 4'h0, 1,  0, 0, 0, 1));
`else
    tbl.push_back(mk(1, 4'hB, 1,  0, 0, 0, 1));
    tbl.push_back(mk(0, 4'h0, 1,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  1, 1, 1, 1));
    tbl.push_back(mk(1, 4'hA, 1,  0, 0, 0, 1));
    tbl.push_back(mk(0, 4'h0, 1,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  1, 1, 0, 0));
    tbl.push_back(mk(1, 4'h5, 1,  0, 1, 1, 1));
    tbl.push_back(mk(0, 4'h0, 1,  0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  1, 1, 1, 1));
    tbl.push_back(mk(1, 4'hC, 1,  0, 0, 0, 1));
    tbl.push_back(mk(1, 4'h7, 1,  1, 1, 0, 0));
    tbl.push_back(mk(1, 4'h7, 0,  1, 1, 0, 0));
    tbl.push_back(mk(1, 4'h7, 0,  1, 1, 0, 0));
    tbl.push_back(mk(1, 4'h7, 0,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1,  0, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0,  0, 1, 1, 0));
    tbl.push_back(mk(0, 4'h0, 1,  0, 1, 1, 1));
    tbl.push_back(mk(0, 4'h0, 1,  0, 0, 0, 1));
`endif
    sipo = 4'h0;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].lv, tbl[i].pd, tbl[i].se);
      $display("row %0d: lv=%b pd=%h se=%b -> sout=%b valid=%b last=%b ready=%b",
               i, tbl[i].lv, tbl[i].pd, tbl[i].se,
               bus.sout, bus.sout_valid, bus.last, bus.load_ready);
      chk_out($sformatf("row%0d", i), tbl[i].sout, tbl[i].sv, tbl[i].last, tbl[i].rdy);
      if (bus.sout_valid && tbl[i].se) sipo = {sipo[2:0], bus.sout};
`ifndef PISO_PARITY_EN
      if (i == 4) chk("sipo q3..q0==1011 bit3", sipo[3], 1'b1);
      if (i == 4) chk("sipo q3..q0==1011 bit2", sipo[2], 1'b0);
      if (i == 4) chk("sipo q3..q0==1011 bit0", sipo[0], 1'b1);
`endif
    end

    // Mid-frame reset aborts immediately, then a clean frame follows.
    mid_word = 4'b0110;
    step(1'b1, mid_word, 1'b1);
    chk("midrst load ready", bus.load_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'h0, 1'b1);
      chk("midrst pre sout", bus.sout, bit_of(mid_word, 3 - i));
    end
    #1 rst_n = 1'b0;
    #1;
    chk_out("midrst abort", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    word = 4'b1001;
    step(1'b1, word, 1'b1);
    chk_out("post_rst idle", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 4'h0, 1'b1);
      chk("post_rst sout", bus.sout, (i < 4) ? bit_of(word, 3 - i) : (^word));
      chk("post_rst last", bus.last, (i == FRAME - 1) ? 1'b1 : 1'b0);
    end
    step(1'b0, 4'h0, 1'b1);
    chk_out("post_rst end", 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized run against a queue of pending serial bits.
    q_bits.delete();
    for (int c = 0; c < 600; c++) begin
      lv   = ($urandom_range(0, 1) == 1);
      se   = ($urandom_range(0, 3) != 0);
      word = 4'($urandom_range(0, 15));
      step(lv, word, se);
      exp_sv = (q_bits.size() != 0);
      exp_so = exp_sv ? q_bits[0] : 1'b0;
      exp_la = (q_bits.size() == 1);
      exp_rd = (q_bits.size() == 0) || ((q_bits.size() == 1) && se);
      chk_out("rand", exp_so, exp_sv, exp_la, exp_rd);
      if (se && (q_bits.size() != 0)) void'(q_bits.pop_front());
      if (lv && exp_rd) begin
        $display("rand cycle %0d: load %h", c, word);
        for (int b = 3; b >= 0; b--) q_bits.push_back(word[b]);
        if (FRAME == 5) q_bits.push_back(^word);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
